// File: rtl/trace_capture.sv
// Trace capture block: samples ALU probe inputs into a record FIFO after a
// settle period, then serializes each record as three 32-bit words
// (op1, op2, res) over a valid/ready stream. Records are dropped when the
// FIFO is full. Capture ends after a fixed number of attempts.
module trace_capture #(
  parameter int unsigned DEPTH       = 8,   // power of 2, >= 2
  parameter int unsigned SETTLE      = 3,   // >= 1
  parameter int unsigned MAX_SAMPLES = 100  // >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_en,
  input  logic [1:0]  cap_sel,
  input  logic [31:0] cap_op1,
  input  logic [31:0] cap_op2,
  input  logic [31:0] cap_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic [1:0]  out_sel,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        done
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Settle counter only needs to reach SETTLE-1.
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CW = $clog2(MAX_SAMPLES + 1);
  localparam int unsigned RW = 2 + 3 * 32;

  localparam logic [SW-1:0] SettleLast  = SW'(SETTLE - 1);
  localparam logic [CW-1:0] AttemptLast = CW'(MAX_SAMPLES - 1);

  localparam logic [1:0] StSettle  = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StStop    = 2'd2;

  localparam logic [1:0] TagOp1 = 2'd0;
  localparam logic [1:0] TagOp2 = 2'd1;
  localparam logic [1:0] TagRes = 2'd2;

  // Control state
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] attempt_q, attempt_d;

  // Record FIFO; the extra pointer bit distinguishes full from empty.
  logic [RW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic [RW-1:0] rd_rec;

  // Serializer and output registers
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [1:0]    out_tag_q, out_tag_d;
  logic [1:0]    out_sel_q, out_sel_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   rec_op2_q, rec_op2_d;
  logic [31:0]   rec_res_q, rec_res_d;

  // Status registers
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          done_q, done_d;

  // Datapath handshakes
  logic          push_req;
  logic          handshake;
  logic          ser_free;
  logic          pop;
  logic          push;
  logic          drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_rec     = mem_q[rd_ptr_q[AW-1:0]];

  assign push_req  = (state_q == StCapture) && cap_en;
  assign handshake = out_valid_q && out_ready;
  // The serializer can take a new record when idle or when the last word
  // of the current record is being accepted this cycle.
  assign ser_free  = !out_valid_q || (handshake && (out_tag_q == TagRes));
  assign pop       = !fifo_empty && ser_free;
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push      = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  // Next-state for the settle / capture / stop sequencing and attempt count
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    attempt_d = attempt_q;
    case (state_q)
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StCapture;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StCapture: begin
        if (cap_en) begin
          attempt_d = attempt_q + 1'b1;
          if (attempt_q == AttemptLast) begin
            state_d = StStop;
          end
        end
      end
      default: begin
        // StStop is left only through reset.
      end
    endcase
  end

  // Next-state for FIFO pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Next-state for the serializer: load on pop, otherwise step tags on handshake
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    rec_op2_d   = rec_op2_q;
    rec_res_d   = rec_res_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_tag_d   = TagOp1;
      out_last_d  = 1'b0;
      out_sel_d   = rd_rec[97:96];
      out_data_d  = rd_rec[95:64];
      rec_op2_d   = rd_rec[63:32];
      rec_res_d   = rd_rec[31:0];
    end else if (handshake) begin
      case (out_tag_q)
        TagOp1: begin
          out_tag_d  = TagOp2;
          out_data_d = rec_op2_q;
        end
        TagOp2: begin
          out_tag_d  = TagRes;
          out_data_d = rec_res_q;
          out_last_d = 1'b1;
        end
        default: begin
          out_valid_d = 1'b0;
          out_tag_d   = TagOp1;
          out_last_d  = 1'b0;
        end
      endcase
    end
  end

  // Next-state for overflow, saturating drop counter and sticky done
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end
    done_d = done_q || ((state_q == StStop) && fifo_empty && !out_valid_q);
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cap_sel, cap_op1, cap_op2, cap_res};
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StSettle;
      settle_q     <= '0;
      attempt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      out_sel_q    <= '0;
      out_last_q   <= 1'b0;
      rec_op2_q    <= '0;
      rec_res_q    <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      attempt_q    <= attempt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      out_sel_q    <= out_sel_d;
      out_last_q   <= out_last_d;
      rec_op2_q    <= rec_op2_d;
      rec_res_q    <= rec_res_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      done_q       <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_sel    = out_sel_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign done       = done_q;

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning record FIFO depth in records (power of 2, at least 2).
REQ-002 SHALL have parameter SETTLE, default 3, meaning the number of cycles to wait after reset deassertion before capture starts.
REQ-003 SHALL have parameter MAX_SAMPLES, default 100, meaning the number of capture attempts after which capture stops.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cap_en, input, 1 bit: sample the probe inputs this cycle.
REQ-007 SHALL have port cap_sel, input, 2 bits: probed ALU select.
REQ-008 SHALL have ports cap_op1 and cap_op2, input, 32 bits each: probed operands.
REQ-009 SHALL have port cap_res, input, 32 bits: probed result.
REQ-010 SHALL have port out_valid, output, 1 bit: an output word is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-012 SHALL have port out_data, output, 32 bits: the serialized record word.
REQ-013 SHALL have port out_tag, output, 2 bits: word index, 0=op1, 1=op2, 2=res.
REQ-014 SHALL have port out_sel, output, 2 bits: cap_sel of the record currently being emitted.
REQ-015 SHALL have port out_last, output, 1 bit: high on tag 2 only.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a record was dropped.
REQ-017 SHALL have port drop_count, output, 8 bits: dropped records, saturating at 255.
REQ-018 SHALL have port done, output, 1 bit: capture finished and all records drained.

Function
REQ-019 SHALL implement FSM states SETTLE, CAPTURE and STOP, entering SETTLE on reset.
REQ-020 SHALL have SETTLE count cycles after reset deassertion and go to CAPTURE after exactly SETTLE cycles, so the first capturable cycle is edge SETTLE+1 after deassertion.
REQ-021 SHALL ignore cap_en in SETTLE and in STOP.
REQ-022 SHALL, in CAPTURE with cap_en=1, count one attempt and push {cap_sel, cap_op1, cap_op2, cap_res} on the same edge, unless the FIFO is full.
REQ-023 SHALL treat a push into a full FIFO with a pop on the same edge as accepted, with no drop.
REQ-024 SHALL, on a push into a full FIFO with no pop, drop the record, set overflow, and increment drop_count (saturating); the attempt is still counted.
REQ-025 SHALL move the FSM to STOP on the edge that completes the MAX_SAMPLES-th attempt; STOP is exited only by reset.
REQ-026 SHALL have the serializer pop one record when idle and the FIFO is non-empty, then present tags 0, 1, 2 in order, one word per handshake (out_valid && out_ready).
REQ-027 SHALL present the first word of a popped record on the cycle after the pop, giving a minimum latency of 1 cycle from push to out_valid when the FIFO is empty and the serializer is idle.
REQ-028 SHALL hold out_data, out_tag, out_sel and out_last stable while out_valid=1 and out_ready=0.
REQ-029 SHALL keep out_valid high until the handshake completes.
REQ-030 SHALL allow the serializer to pop the next record on the same edge as the tag-2 handshake, giving back-to-back records with no bubble.
REQ-031 SHALL sustain a throughput of at most one record per 3 cycles; capture of faster bursts relies on FIFO buffering.
REQ-032 SHALL assert done when all of the following hold: state STOP, FIFO empty, serializer idle; once asserted, done stays high until reset.
REQ-033 SHALL allow the FIFO pointers to wrap modulo DEPTH, with one extra pointer bit used to tell full from empty.

Reset
REQ-034 SHALL, on assertion of reset, asynchronously clear: FSM to SETTLE, settle counter 0, attempt counter 0, FIFO to empty, serializer to idle.
REQ-035 SHALL, on assertion of reset, asynchronously set these outputs: out_valid=0, out_data=0, out_tag=0, out_sel=0, out_last=0, overflow=0, drop_count=0, done=0.
REQ-036 SHALL, when reset is asserted mid-record (including while out_valid=1), drop the partial record; no word is emitted after reset until a new capture occurs.
REQ-037 SHALL register every output directly from a flop.

Verification
REQ-038 SHALL be verified by a settle test: deassert reset and hold cap_en=1 → the first record pushed at edge 4 after deassertion; no out_valid before edge 5.
REQ-039 SHALL be verified by a stream test: out_ready=1; capture op1=0x5, op2=0xA, res=0xF, sel=2'b01 → words 0x5/tag0, 0xA/tag1, 0xF/tag2 with last=1, out_sel=01 on all three.
REQ-040 SHALL be verified by a backpressure test: out_ready=0 for 20 cycles while cap_en=1 → 8 records stored plus 1 in the serializer, drop_count=11, overflow=1; out_data held stable throughout.
REQ-041 SHALL be verified by a stop test: MAX_SAMPLES=100 with cap_en=1 and out_ready=1 → exactly 100 attempts counted; done rises after the last tag-2 handshake; cap_en afterwards has no effect.
REQ-042 SHALL be verified by a full push/pop test: FIFO full, with a pop and cap_en on the same edge → drop_count unchanged and occupancy stays at DEPTH.
REQ-043 SHALL be verified by a mid-record reset test: reset pulsed during tag 1 → out_valid=0 immediately (asynchronous), and all counters and flags read 0.
